// File: rtl/stats_graph_render_if.sv
// Sample/VGA bundle between the game engine, VGA timing and the stats graph renderer.
// The master side drives samples and raw timing; the slave side returns delayed timing and pixels.
interface stats_graph_render_if #(
  parameter int unsigned POP_WIDTH = 18,
  parameter int unsigned HCOUNT_W  = 11,
  parameter int unsigned VCOUNT_W  = 10
);
  logic                 clear_in;
  logic                 gen_done_in;
  logic [POP_WIDTH-1:0] pop_count_in;

  logic [HCOUNT_W-1:0]  hcount_in;
  logic [VCOUNT_W-1:0]  vcount_in;
  logic                 hsync_in;
  logic                 vsync_in;
  logic                 blank_in;

  logic [HCOUNT_W-1:0]  hcount_out;
  logic [VCOUNT_W-1:0]  vcount_out;
  logic                 hsync_out;
  logic                 vsync_out;
  logic                 blank_out;
  logic [11:0]          pixel_out;

  modport master (
    output clear_in, gen_done_in, pop_count_in,
    output hcount_in, vcount_in, hsync_in, vsync_in, blank_in,
    input  hcount_out, vcount_out, hsync_out, vsync_out, blank_out, pixel_out
  );

  modport slave (
    input  clear_in, gen_done_in, pop_count_in,
    input  hcount_in, vcount_in, hsync_in, vsync_in, blank_in,
    output hcount_out, vcount_out, hsync_out, vsync_out, blank_out, pixel_out
  );
endinterface

// File: rtl/stats_graph_render.sv
// Scrolling population-history bar graph: 128-sample circular buffer rendered into a fixed
// window of the VGA raster with a 2-cycle pixel pipeline.
module stats_graph_render #(
  parameter int unsigned POP_WIDTH      = 18,
  parameter int unsigned POP_SHIFT      = 11,
  parameter int unsigned SAMPLE_PERIOD  = 2,
  parameter logic [11:0] GRAPH_COLOR    = 12'h0FF,
  parameter int unsigned HCOUNT_W       = 11,
  parameter int unsigned VCOUNT_W       = 10,
  parameter int unsigned GRAPH_WIDTH    = 128,
  parameter int unsigned GRAPH_HEIGHT   = 128,
  parameter int unsigned GRAPH_ORIGIN_X = 490,
  parameter int unsigned GRAPH_ORIGIN_Y = 10
) (
  input logic             clk_in,
  input logic             rst_n_in,
  stats_graph_render_if.slave bus
);

  localparam int unsigned DEPTH   = 128;
  localparam int unsigned AW      = 7;
  localparam int unsigned HW      = 7;
  localparam int unsigned PHASE_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [PHASE_W-1:0]   PHASE_LAST = PHASE_W'(SAMPLE_PERIOD - 1);
  localparam logic [HCOUNT_W-1:0]  X_LO       = HCOUNT_W'(GRAPH_ORIGIN_X);
  localparam logic [HCOUNT_W-1:0]  X_HI       = HCOUNT_W'(GRAPH_ORIGIN_X + GRAPH_WIDTH);
  localparam logic [VCOUNT_W-1:0]  Y_LO       = VCOUNT_W'(GRAPH_ORIGIN_Y);
  localparam logic [VCOUNT_W-1:0]  Y_HI       = VCOUNT_W'(GRAPH_ORIGIN_Y + GRAPH_HEIGHT);
  localparam logic [POP_WIDTH-1:0] H_MAX_POP  = POP_WIDTH'(GRAPH_HEIGHT - 1);
  localparam logic [HW-1:0]        H_MAX      = HW'(GRAPH_HEIGHT - 1);

  typedef struct packed {
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic                hsync;
    logic                vsync;
    logic                blank;
  } vga_t;

  localparam vga_t VGA_RST = '{hcount: '0, vcount: '0, hsync: 1'b0, vsync: 1'b0, blank: 1'b1};

  // ---------------------------------------------------------------------------
  // Sampling
  // ---------------------------------------------------------------------------
  logic [POP_WIDTH-1:0] w_pop_shift;
  logic [HW-1:0]        w_height;
  logic                 w_sample_we;

  logic [PHASE_W-1:0]   r_phase;
  logic [AW-1:0]        r_wr_ptr;
  logic [HW-1:0]        r_buf [DEPTH];

  // Shift at full width first so large counts saturate instead of wrapping.
  assign w_pop_shift = bus.pop_count_in >> POP_SHIFT;
  assign w_height    = (w_pop_shift > H_MAX_POP) ? H_MAX : w_pop_shift[HW-1:0];
  assign w_sample_we = bus.gen_done_in && !bus.clear_in && (r_phase == PHASE_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_phase  <= '0;
      r_wr_ptr <= '0;
    end else if (bus.clear_in) begin
      r_phase  <= '0;
      r_wr_ptr <= '0;
    end else if (bus.gen_done_in) begin
      if (r_phase == PHASE_LAST) begin
        r_phase  <= '0;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end else begin
        r_phase  <= r_phase + PHASE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (bus.clear_in) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (w_sample_we) begin
      r_buf[r_wr_ptr] <= w_height;
    end
  end

  // ---------------------------------------------------------------------------
  // Render stage 1: window decode and history read
  // ---------------------------------------------------------------------------
  logic          w_in_win;
  logic [AW-1:0] w_col;
  logic [HW-1:0] w_row;
  logic [AW-1:0] w_rd_addr;

  logic          r_in_win_s1;
  logic [HW-1:0] r_row_s1;
  logic [HW-1:0] r_rd_data_s1;

  assign w_in_win = !bus.blank_in &&
                    (bus.hcount_in >= X_LO) && (bus.hcount_in < X_HI) &&
                    (bus.vcount_in >= Y_LO) && (bus.vcount_in < Y_HI);
  assign w_col     = AW'(bus.hcount_in - X_LO);
  assign w_row     = HW'(bus.vcount_in - Y_LO);
  // Oldest sample lands in column 0, newest (wr_ptr-1) in the last column.
  assign w_rd_addr = r_wr_ptr + w_col;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_in_win_s1  <= 1'b0;
      r_row_s1     <= '0;
      r_rd_data_s1 <= '0;
    end else begin
      r_in_win_s1  <= w_in_win;
      r_row_s1     <= w_row;
      r_rd_data_s1 <= r_buf[w_rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Render stage 2: bar fill compare
  // ---------------------------------------------------------------------------
  logic [HW-1:0] w_thresh;
  logic          w_lit;
  logic [11:0]   r_pixel;

  assign w_thresh = H_MAX - r_rd_data_s1;
  assign w_lit    = r_in_win_s1 && (r_row_s1 >= w_thresh);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pixel <= '0;
    end else begin
      r_pixel <= w_lit ? GRAPH_COLOR : 12'h000;
    end
  end

  // ---------------------------------------------------------------------------
  // VGA timing delay
  // ---------------------------------------------------------------------------
  vga_t w_vga_in;
  vga_t r_vga_s1;
  vga_t r_vga_s2;

  assign w_vga_in = '{hcount: bus.hcount_in, vcount: bus.vcount_in,
                      hsync: bus.hsync_in, vsync: bus.vsync_in, blank: bus.blank_in};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_vga_s1 <= VGA_RST;
      r_vga_s2 <= VGA_RST;
    end else begin
      r_vga_s1 <= w_vga_in;
      r_vga_s2 <= r_vga_s1;
    end
  end

  assign bus.hcount_out = r_vga_s2.hcount;
  assign bus.vcount_out = r_vga_s2.vcount;
  assign bus.hsync_out  = r_vga_s2.hsync;
  assign bus.vsync_out  = r_vga_s2.vsync;
  assign bus.blank_out  = r_vga_s2.blank;
  assign bus.pixel_out  = r_pixel;

endmodule

// File: tb/tb_stats_graph_render.sv
// Directed bench for the stats graph renderer: sampling, scaling, wrap, clear and window edges.
module tb_stats_graph_render;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  stats_graph_render_if #(.POP_WIDTH(18), .HCOUNT_W(11), .VCOUNT_W(10)) bus ();

  stats_graph_render dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vga(input int h, input int v, input logic blank);
    bus.hcount_in = 11'(h);
    bus.vcount_in = 10'(v);
    bus.hsync_in  = 1'b0;
    bus.vsync_in  = 1'b0;
    bus.blank_in  = blank;
  endtask

  task automatic probe(input int h, input int v, input logic blank, output logic [11:0] px);
    set_vga(h, v, blank);
    tick();
    tick();
    px = bus.pixel_out;
    set_vga(0, 0, 1'b1);
  endtask

  // Streams a rectangle through the pipeline and counts pixels lit with the graph colour.
  task automatic scan(input int h0, input int h1, input int v0, input int v1, output int cnt);
    cnt = 0;
    set_vga(0, 0, 1'b1);
    tick();
    tick();
    for (int v = v0; v <= v1; v++) begin
      for (int h = h0; h <= h1; h++) begin
        set_vga(h, v, 1'b0);
        tick();
        if (bus.pixel_out == 12'h0FF) cnt++;
      end
    end
    set_vga(0, 0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      if (bus.pixel_out == 12'h0FF) cnt++;
    end
  endtask

  task automatic gen(input int pop);
    bus.gen_done_in  = 1'b1;
    bus.pop_count_in = 18'(pop);
    tick();
    bus.gen_done_in  = 1'b0;
  endtask

  logic [11:0] px;
  int          cnt;
  int          hh [8];
  int          vv [8];
  logic [2:0]  ff [8];

  initial begin
    rst_n            = 1'b0;
    bus.clear_in     = 1'b0;
    bus.gen_done_in  = 1'b0;
    bus.pop_count_in = '0;
    set_vga(300, 50, 1'b0);
    #22;
    check("rst_pixel", 32'(bus.pixel_out), 32'h0);
    check("rst_blank", 32'(bus.blank_out), 32'h1);
    check("rst_hcount", 32'(bus.hcount_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    set_vga(0, 0, 1'b1);
    tick();

    // VGA passthrough delay
    for (int i = 0; i < 8; i++) begin
      hh[i] = 100 + i * 3;
      vv[i] = 20 + i;
      ff[i] = 3'(i);
      bus.hcount_in = 11'(hh[i]);
      bus.vcount_in = 10'(vv[i]);
      bus.hsync_in  = ff[i][0];
      bus.vsync_in  = ff[i][1];
      bus.blank_in  = ff[i][2];
      tick();
      if (i >= 1) begin
        check("vga_hcount", 32'(bus.hcount_out), 32'(hh[i-1]));
        check("vga_vcount", 32'(bus.vcount_out), 32'(vv[i-1]));
        check("vga_flags", 32'({bus.hsync_out, bus.vsync_out, bus.blank_out}),
              32'({ff[i-1][0], ff[i-1][1], ff[i-1][2]}));
      end
    end

    // Empty history: bottom row only
    scan(488, 619, 137, 137, cnt);
    check("empty_row137", 32'(cnt), 32'd128);
    scan(488, 619, 136, 136, cnt);
    check("empty_row136", 32'(cnt), 32'd0);
    scan(489, 490, 8, 139, cnt);
    check("empty_leftedge", 32'(cnt), 32'd1);

    // Period-2 sampling: first pulse only advances phase
    gen(1000);
    scan(617, 617, 8, 139, cnt);
    check("phase_nowrite", 32'(cnt), 32'd1);
    gen(230400);
    scan(617, 617, 8, 139, cnt);
    check("h112_col617", 32'(cnt), 32'd113);
    probe(617, 25, 1'b0, px);
    check("h112_top_lit", 32'(px), 32'h0FF);
    probe(617, 24, 1'b0, px);
    check("h112_above_dark", 32'(px), 32'h0);
    probe(616, 25, 1'b0, px);
    check("h112_col616_dark", 32'(px), 32'h0);

    // Max height, then minimum height
    gen(262143);
    gen(262143);
    scan(617, 617, 8, 139, cnt);
    check("h127_col617", 32'(cnt), 32'd128);
    scan(616, 616, 8, 139, cnt);
    check("h112_scrolled", 32'(cnt), 32'd113);
    probe(617, 138, 1'b0, px);
    check("below_win_dark", 32'(px), 32'h0);
    probe(617, 9, 1'b0, px);
    check("above_win_dark", 32'(px), 32'h0);
    gen(2047);
    gen(2047);
    scan(617, 617, 8, 139, cnt);
    check("h0_col617", 32'(cnt), 32'd1);
    scan(616, 616, 8, 139, cnt);
    check("h127_scrolled", 32'(cnt), 32'd128);

    // Clear wins over a coincident sample
    gen(230400);
    bus.clear_in     = 1'b1;
    bus.gen_done_in  = 1'b1;
    bus.pop_count_in = 18'd262143;
    tick();
    bus.clear_in     = 1'b0;
    bus.gen_done_in  = 1'b0;
    scan(490, 617, 10, 137, cnt);
    check("clear_window", 32'(cnt), 32'd128);
    gen(230400);
    scan(617, 617, 8, 139, cnt);
    check("clear_phase0", 32'(cnt), 32'd1);
    gen(230400);
    scan(617, 617, 8, 139, cnt);
    check("clear_ptr0", 32'(cnt), 32'd113);

    // 130 samples: pointer wraps to 2
    bus.clear_in = 1'b1;
    tick();
    bus.clear_in = 1'b0;
    for (int i = 0; i < 130; i++) begin
      gen((i % 128) << 11);
      gen((i % 128) << 11);
    end
    scan(490, 490, 8, 139, cnt);
    check("wrap_col490", 32'(cnt), 32'd3);
    scan(491, 491, 8, 139, cnt);
    check("wrap_col491", 32'(cnt), 32'd4);
    scan(617, 617, 8, 139, cnt);
    check("wrap_col617", 32'(cnt), 32'd2);

    // Window edges and blanking (column 553 holds h=65)
    probe(553, 72, 1'b0, px);
    check("mid_top_lit", 32'(px), 32'h0FF);
    probe(553, 71, 1'b0, px);
    check("mid_above_dark", 32'(px), 32'h0);
    probe(553, 137, 1'b1, px);
    check("blank_dark", 32'(px), 32'h0);
    probe(489, 137, 1'b0, px);
    check("h489_dark", 32'(px), 32'h0);
    probe(618, 137, 1'b0, px);
    check("h618_dark", 32'(px), 32'h0);
    probe(553, 9, 1'b0, px);
    check("v9_dark", 32'(px), 32'h0);
    probe(553, 138, 1'b0, px);
    check("v138_dark", 32'(px), 32'h0);

    // Read-before-write on buf[2] (old h=2, new h=127)
    gen(0);
    bus.gen_done_in  = 1'b1;
    bus.pop_count_in = 18'(127 << 11);
    set_vga(490, 10, 1'b0);
    tick();
    bus.gen_done_in = 1'b0;
    set_vga(617, 10, 1'b0);
    tick();
    check("rbw_old_value", 32'(bus.pixel_out), 32'h0);
    set_vga(0, 0, 1'b1);
    tick();
    check("rbw_new_value", 32'(bus.pixel_out), 32'h0FF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stats_graph_render.md
Name: stats_graph_render

Overview:
- Downstream consumer of per-generation population counts from the game engine.
- Keeps a 128-sample scrolling history in a circular buffer and renders it as a filled bar graph in the GRAPH_WIDTH x GRAPH_HEIGHT window at (GRAPH_ORIGIN_X, GRAPH_ORIGIN_Y).
- Sits in the VGA pixel pipeline beside the board renderer. Its pixel output is OR-merged by the top-level compositor.

Parameters:
- POP_WIDTH, 18, width of the population count (BOARD_SIZE^2 = 230400 < 2^18).
- POP_SHIFT, 11, right shift that maps population to bar height (230400>>11 = 112).
- SAMPLE_PERIOD, GRAPH_SAMPLE_PERIOD (2), number of generations per stored sample.
- GRAPH_COLOR, 12'h0FF, colour of lit graph pixels.
- Window geometry comes from the common header constants GRAPH_WIDTH, GRAPH_HEIGHT, GRAPH_ORIGIN_X and GRAPH_ORIGIN_Y.

Ports:
- clk_in  input  1  pixel/system clock
- rst_n_in  input  1  asynchronous active-low reset
- clear_in  input  1  synchronous clear of history (pulsed on seed load)
- gen_done_in  input  1  one-cycle pulse at end of each generation
- pop_count_in  input  POP_WIDTH  live-cell count, valid when gen_done_in=1
- vga_in  input  vga_t  hcount/vcount/hsync/vsync/blank from VGA timing generator
- vga_out  output  vga_t  vga_in delayed 2 cycles
- pixel_out  output  12  graph pixel colour aligned with vga_out

Behaviour:
- Reset (rst_n_in=0, async):
  - all 128 buffer entries, wr_ptr and phase cleared to 0;
  - pixel_out=0 and vga_out fields 0, with blank_out=1.
- Sampling:
  - phase counter runs 0..SAMPLE_PERIOD-1 and advances only on gen_done_in;
  - on gen_done_in with phase==SAMPLE_PERIOD-1: write h to buf[wr_ptr], then wr_ptr<=wr_ptr+1 (7-bit, wraps 127->0) and phase<=0;
  - with SAMPLE_PERIOD=1, every pulse writes.
- Scaling: h = min(pop_count_in >> POP_SHIFT, GRAPH_HEIGHT-1), 7 bits, saturating. The shift is computed at full width before truncation.
- clear_in:
  - same effect as reset on buffer, wr_ptr and phase; the VGA pipeline is unaffected;
  - if clear_in and gen_done_in are both high, clear wins and the sample is dropped.
- Render pipeline, latency 2:
  - Stage 1:
    - in_win = !blank && hcount in [ORIGIN_X, ORIGIN_X+WIDTH) && vcount in [ORIGIN_Y, ORIGIN_Y+HEIGHT);
    - col = hcount-ORIGIN_X, row = vcount-ORIGIN_Y;
    - register rd_data = buf[(wr_ptr+col) mod 128], so the oldest sample is at the left and the newest (wr_ptr-1) at column 127;
    - register in_win and row.
  - Stage 2: pixel_out = (in_win_d && row_d >= GRAPH_HEIGHT-1-rd_data) ? GRAPH_COLOR : 0.
  - Result: h=0 lights only the bottom row; h=127 lights the full column.
- Same-cycle write and read of one address: read returns the pre-write value (read-before-write). The next read sees the new value.
- vga_out is a pure 2-stage shift of vga_in and is never gated.
- Comparisons use unsigned arithmetic wide enough for hcount/vcount. No underflow is possible because window bounds are checked before subtraction is used.

Test Plan:
- Reset → release with vga_in sweeping the window: pixel_out=12'h0FF only on row 127 (vcount=137) for hcount 490..617, 0 elsewhere; vga_out equals vga_in delayed exactly 2 cycles.
- Two gen_done pulses with pop 1000 then 230400 (period 2) → one sample of h=112 written at the newest column. Pixel (617, 10+15=25) is lit; (617, 24) and (616, 25) are dark.
- Pop 262143 → h saturates to 127, column 617 fully lit rows 10..137. Pop 2047 → h=0, bottom row only.
- 130 samples with h=sample_index mod 128 → wr_ptr wraps to 2; column 490 shows h=2 and column 617 shows h=1.
- clear_in asserted together with gen_done_in → no write, wr_ptr=0, phase=0, graph shows bottom row only.
- blank_in=1 inside window coordinates → pixel_out=0. hcount=489/618 or vcount=9/138 → pixel_out=0 regardless of buffer contents.
